// File: rtl/wb_line_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_line_pkg
// Description : Shared widths, FSM state encoding and request record for the
//               Wishbone 256-bit line responder.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_line_pkg;

    localparam int LINE_W = 256;
    localparam int SEL_W  = LINE_W / 8;
    localparam int ADR_W  = 27;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    typedef struct packed {
        logic              we;
        logic [SEL_W-1:0]  sel;
        logic [ADR_W-1:0]  adr;
        logic [LINE_W-1:0] dat;
    } wb_req_t;

endpackage
`default_nettype wire

// File: rtl/wb_line_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_line_responder_if
// Description : Wishbone line-bus signal bundle with initiator (master) and
//               responder (slave) views.
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_line_responder_if;
    import wb_line_pkg::*;

    logic              CYC;
    logic              STB;
    logic              WE;
    logic [SEL_W-1:0]  SEL;
    logic [ADR_W-1:0]  ADR;
    logic [LINE_W-1:0] DAT_M;
    logic [LINE_W-1:0] DAT_S;
    logic              ACK;
    logic [31:0]       rd_count;
    logic [31:0]       wr_count;

    modport master (
        output CYC, STB, WE, SEL, ADR, DAT_M,
        input  DAT_S, ACK, rd_count, wr_count
    );

    modport slave (
        input  CYC, STB, WE, SEL, ADR, DAT_M,
        output DAT_S, ACK, rd_count, wr_count
    );

endinterface
`default_nettype wire

// File: rtl/wb_line_responder_line_ram.sv
`default_nettype none
// ============================================================================
// Module      : line_ram
// Description : Single-port line store, byte-enable write, combinational read.
// Revision    : 1.0 - initial release
// ============================================================================
module line_ram #(
    parameter int DEPTH_LOG2 = 8,
    parameter int LINE_W     = 256,
    parameter int SEL_W      = LINE_W / 8
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [SEL_W-1:0]      i_sel,
    input  logic [DEPTH_LOG2-1:0] i_addr,
    input  logic [LINE_W-1:0]     i_wdata,
    output logic [LINE_W-1:0]     o_rdata
);

    localparam int c_DEPTH = 1 << DEPTH_LOG2;

    logic [LINE_W-1:0] r_mem [c_DEPTH];

    // Contents are deliberately never reset: the store survives rst.
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < SEL_W; b++) begin
                if (i_sel[b]) begin
                    r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule
`default_nettype wire

// File: rtl/wb_line_responder.sv
`default_nettype none
// ============================================================================
// Module      : wb_line_responder
// Description : Wishbone slave for 256-bit line transfers with a fixed,
//               programmable ACK latency and a synthesizable line store.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_line_responder
    import wb_line_pkg::*;
#(
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 4
) (
    input  logic              clk,
    input  logic              rst,
    wb_line_responder_if.slave wb
);

    localparam logic [3:0] c_CNT_INIT = 4'(LATENCY - 1);

    state_t            r_state;
    state_t            w_state_next;
    logic [3:0]        r_cnt;
    logic [3:0]        w_cnt_next;
    logic              w_accept;
    wb_req_t           r_req;
    logic [31:0]       r_rd_count;
    logic [31:0]       r_wr_count;
    logic              w_req_valid;
    logic              w_resp;
    logic              w_ram_we;
    logic [LINE_W-1:0] w_rdata;

    assign w_req_valid = wb.CYC & wb.STB;
    assign w_resp      = (r_state == ST_RESP) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_rd_count <= '0;
            r_wr_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (r_state == ST_RESP) begin
                if (r_req.we) begin
                    r_wr_count <= r_wr_count + 32'd1;
                end else begin
                    r_rd_count <= r_rd_count + 32'd1;
                end
            end
        end
    end

    // Request fields are frozen at acceptance; later bus changes are ignored.
    always_ff @(posedge clk) begin
        if (w_accept && !rst) begin
            r_req <= '{we: wb.WE, sel: wb.SEL, adr: wb.ADR, dat: wb.DAT_M};
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req_valid) begin
                    w_accept     = 1'b1;
                    w_cnt_next   = c_CNT_INIT;
                    w_state_next = (LATENCY == 1) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A dropped strobe abandons the request before it commits.
                if (!w_req_valid) begin
                    w_state_next = ST_IDLE;
                end else if (r_cnt == 4'd1) begin
                    w_state_next = ST_RESP;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            ST_RESP: w_state_next = ST_HOLD;
            ST_HOLD: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign w_ram_we = w_resp && r_req.we;

    line_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .LINE_W     (LINE_W),
        .SEL_W      (SEL_W)
    ) u_line_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_sel   (r_req.sel),
        .i_addr  (r_req.adr[DEPTH_LOG2-1:0]),
        .i_wdata (r_req.dat),
        .o_rdata (w_rdata)
    );

    assign wb.ACK      = w_resp;
    assign wb.DAT_S    = (w_resp && !r_req.we) ? w_rdata : '0;
    assign wb.rd_count = r_rd_count;
    assign wb.wr_count = r_wr_count;

endmodule
`default_nettype wire

// File: tb/tb_wb_line_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_line_responder
// Description : Self-checking bench for wb_line_responder at LATENCY 4 and 1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_line_responder;
    import wb_line_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cyc = 1'b0;
    logic         stb = 1'b0;
    logic         we  = 1'b0;
    logic [31:0]  sel = '0;
    logic [26:0]  adr = '0;
    logic [255:0] datm = '0;
    int           dsel = 0;

    always #5 clk = ~clk;

    wb_line_responder_if bus4 ();
    wb_line_responder_if bus1 ();

    assign bus4.CYC   = cyc && (dsel == 0);
    assign bus4.STB   = stb && (dsel == 0);
    assign bus4.WE    = we;
    assign bus4.SEL   = sel;
    assign bus4.ADR   = adr;
    assign bus4.DAT_M = datm;
    assign bus1.CYC   = cyc && (dsel == 1);
    assign bus1.STB   = stb && (dsel == 1);
    assign bus1.WE    = we;
    assign bus1.SEL   = sel;
    assign bus1.ADR   = adr;
    assign bus1.DAT_M = datm;

    wb_line_responder #(.DEPTH_LOG2(8), .LATENCY(4)) u_dut4 (.clk(clk), .rst(rst), .wb(bus4));
    wb_line_responder #(.DEPTH_LOG2(8), .LATENCY(1)) u_dut1 (.clk(clk), .rst(rst), .wb(bus1));

    logic         ack;
    logic [255:0] dats;
    logic [31:0]  rdc;
    logic [31:0]  wrc;
    assign ack  = (dsel == 1) ? bus1.ACK      : bus4.ACK;
    assign dats = (dsel == 1) ? bus1.DAT_S    : bus4.DAT_S;
    assign rdc  = (dsel == 1) ? bus1.rd_count : bus4.rd_count;
    assign wrc  = (dsel == 1) ? bus1.wr_count : bus4.wr_count;

    // Reference model: one byte-addressable line array per DUT plus counts.
    logic [255:0] mm  [2][256];
    bit           vld [2][256];
    int unsigned  mrd [2];
    int unsigned  mwr [2];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic txn(input logic w, input logic [31:0] s, input logic [26:0] a,
                       input logic [255:0] d, input int lat, input string nm,
                       output logic [255:0] got);
        int ack_at;
        int acks;
        int bad;
        int idx;
        idx    = int'(a[7:0]);
        ack_at = -1;
        acks   = 0;
        bad    = 0;
        got    = '0;
        cyc = 1'b1; stb = 1'b1; we = w; sel = s; adr = a; datm = d;
        for (int k = 1; k <= lat + 3; k++) begin
            step();
            if (ack) begin
                acks++;
                if (ack_at < 0) begin
                    ack_at = k;
                    got    = dats;
                end
                cyc = 1'b0; stb = 1'b0;
            end else begin
                if (dats != '0) bad++;
                if (acks == 0) begin
                    adr  = 27'($urandom);
                    datm = rnd256();
                    sel  = $urandom;
                    we   = 1'($urandom);
                end
            end
        end
        cyc = 1'b0; stb = 1'b0;
        chk({nm, " ack_cycle"}, 256'(ack_at), 256'(lat));
        chk({nm, " ack_count"}, 256'(acks), 256'd1);
        chk({nm, " dat_s_idle_zero"}, 256'(bad), 256'd0);
        if (w) begin
            for (int b = 0; b < 32; b++) begin
                if (s[b]) mm[dsel][idx][b*8 +: 8] = d[b*8 +: 8];
            end
            if (s == '1) vld[dsel][idx] = 1'b1;
            mwr[dsel]++;
        end else begin
            if (vld[dsel][idx]) chk({nm, " read_data"}, got, mm[dsel][idx]);
            mrd[dsel]++;
        end
        chk({nm, " rd_count"}, 256'(rdc), 256'(mrd[dsel]));
        chk({nm, " wr_count"}, 256'(wrc), 256'(mwr[dsel]));
    endtask

    typedef struct {
        logic         w;
        logic [31:0]  s;
        logic [26:0]  a;
        logic [255:0] d;
        logic [255:0] e;
        string        n;
    } vec_t;

    vec_t vt [6];

    initial begin
        #1_000_000;
        checks++;
        errors++;
        $display("FAIL watchdog expired");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        logic [255:0] got;
        logic [26:0]  la [4];
        int           bad_ack;
        int           bad_dat;
        int           bad_cnt;
        int           acks;
        int           j;

        for (int i = 0; i < 2; i++) begin
            mrd[i] = 0;
            mwr[i] = 0;
            for (int l = 0; l < 256; l++) begin
                mm[i][l]  = '0;
                vld[i][l] = 1'b0;
            end
        end

        vt[0] = '{1'b1, 32'hFFFF_FFFF, 27'h010, {32{8'hA5}}, '0, "wr_full_10"};
        vt[1] = '{1'b0, 32'h0, 27'h010, '0, {32{8'hA5}}, "rd_full_10"};
        vt[2] = '{1'b1, 32'h0000_0001, 27'h010, {{31{8'h11}}, 8'h3C}, '0, "wr_byte0_10"};
        vt[3] = '{1'b0, 32'hFFFF_FFFF, 27'h010, '0, {{31{8'hA5}}, 8'h3C}, "rd_byte0_10"};
        vt[4] = '{1'b1, 32'hF000_000F, 27'h110, {32{8'h5A}}, '0, "wr_alias_110"};
        vt[5] = '{1'b0, 32'h0, 27'h010, '0, {{4{8'h5A}}, {24{8'hA5}}, {4{8'h5A}}}, "rd_alias_10"};

        // Reset, then idle
        repeat (3) step();
        rst = 1'b0;
        bad_ack = 0; bad_dat = 0; bad_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (bus4.ACK || bus1.ACK) bad_ack++;
            if (bus4.DAT_S != '0 || bus1.DAT_S != '0) bad_dat++;
            if (bus4.rd_count != 0 || bus4.wr_count != 0 ||
                bus1.rd_count != 0 || bus1.wr_count != 0) bad_cnt++;
        end
        chk("reset_idle ack", 256'(bad_ack), 256'd0);
        chk("reset_idle dat_s", 256'(bad_dat), 256'd0);
        chk("reset_idle counts", 256'(bad_cnt), 256'd0);

        // Table-driven vectors at LATENCY 4
        dsel = 0;
        for (int i = 0; i < 6; i++) begin
            txn(vt[i].w, vt[i].s, vt[i].a, vt[i].d, 4, vt[i].n, got);
            if (!vt[i].w) chk({vt[i].n, " table"}, got, vt[i].e);
        end

        for (int l = 0; l < 64; l++) begin
            if (!vld[0][l]) txn(1'b1, '1, 27'(l), rnd256(), 4, "init4", got);
        end

        // Strobe dropped in the second WAIT cycle of a write
        cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = '1; adr = 27'h020; datm = {32{8'hFF}};
        step();
        step();
        stb = 1'b0;
        acks = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            cyc = 1'b0;
            if (ack) acks++;
        end
        chk("abort ack", 256'(acks), 256'd0);
        chk("abort wr_count", 256'(wrc), 256'(mwr[0]));
        txn(1'b0, '0, 27'h020, '0, 4, "abort_readback", got);

        // Reset during WAIT of a write
        cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = '1; adr = 27'h030; datm = {32{8'hC3}};
        step();
        step();
        rst = 1'b1;
        step();
        chk("rst_wait ack_in_reset", 256'(bus4.ACK), 256'd0);
        rst = 1'b0; cyc = 1'b0; stb = 1'b0;
        acks = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (bus4.ACK || bus1.ACK) acks++;
        end
        chk("rst_wait ack_after", 256'(acks), 256'd0);
        mrd[0] = 0; mwr[0] = 0; mrd[1] = 0; mwr[1] = 0;
        chk("rst_wait counts4", 256'({bus4.rd_count, bus4.wr_count}), 256'd0);
        chk("rst_wait counts1", 256'({bus1.rd_count, bus1.wr_count}), 256'd0);
        txn(1'b0, '0, 27'h030, '0, 4, "rst_wait_readback", got);

        // Randomized traffic against the model, LATENCY 4
        for (int i = 0; i < 40; i++) begin
            txn(1'($urandom), ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom,
                {19'($urandom), 8'($urandom_range(0, 63))}, rnd256(), 4, "rand4", got);
        end

        // LATENCY 1 device
        dsel = 1;
        txn(1'b1, '1, 27'h000, rnd256(), 1, "init1_l0", got);
        txn(1'b1, '1, 27'h001, rnd256(), 1, "init1_l1", got);
        for (int i = 0; i < 12; i++) begin
            txn(1'($urandom), ($urandom_range(0, 2) == 0) ? 32'hFFFF_FFFF : $urandom,
                {19'($urandom), 8'($urandom_range(0, 1))}, rnd256(), 1, "rand1", got);
        end

        // Back-to-back reads with STB held: ACKs every third cycle
        la[0] = 27'h100; la[1] = 27'h001; la[2] = 27'h300; la[3] = 27'h101;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = $urandom; adr = la[0];
        j = 0;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (ack) begin
                if (j < 4) begin
                    chk("b2b ack_cycle", 256'(k), 256'(1 + 3 * j));
                    chk("b2b read_data", dats, mm[1][int'(la[j][7:0])]);
                    mrd[1]++;
                end
                j++;
                if (j < 4) adr = la[j];
                else begin
                    cyc = 1'b0; stb = 1'b0;
                end
            end
        end
        cyc = 1'b0; stb = 1'b0;
        chk("b2b ack_count", 256'(j), 256'd4);
        chk("b2b rd_count", 256'(rdc), 256'(mrd[1]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
